// File: rtl/screen_sequencer.sv
// screen_sequencer: pinball game-flow FSM (intro/level reset/launch/play/over/win); define SCREEN_PAUSE_EN to add the PAUSED state
module screen_sequencer #(
  parameter int RESET_FRAMES = 60,
  parameter int END_FRAMES   = 180,
  parameter int WIN_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       startOfFrame,
  input  logic       start,
  input  logic       key5IsPressed,
  input  logic       collisionBallBottom,
  input  logic [3:0] life,
  input  logic [3:0] score,
  input  logic       pauseKey,
  output logic [1:0] screenSel,
  output logic       reset_level,
  output logic       reset_level_pulse,
  output logic       pause,
  output logic       gameActive
);
  localparam logic [7:0] RESET_LOAD = 8'(RESET_FRAMES);
  localparam logic [7:0] END_LOAD   = 8'(END_FRAMES);
  localparam logic [3:0] WIN_LIM    = 4'(WIN_SCORE);
  typedef enum logic [2:0] {
    S_INTRO, S_LEVEL_RESET, S_LAUNCH, S_PLAY, S_GAME_OVER, S_WIN
`ifdef SCREEN_PAUSE_EN
    , S_PAUSED
`endif
  } state_t;
  state_t     r_state, w_next;
  logic [7:0] r_cnt;
  logic       r_key5_d;
  logic       w_key5_rise, w_sof_last, w_entry;
`ifdef SCREEN_PAUSE_EN
  logic       r_pause_d;
  logic       w_pause_rise;
  assign w_pause_rise = pauseKey & ~r_pause_d;
`else
  logic       w_unused_pause;
  assign w_unused_pause = pauseKey;
`endif
  assign w_key5_rise = key5IsPressed & ~r_key5_d;
  assign w_sof_last  = startOfFrame && r_cnt <= 8'd1;
  assign w_entry     = w_next != r_state;
  // next-state selection, transitions checked in priority order
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INTRO:       if (start) w_next = S_LEVEL_RESET;
      S_LEVEL_RESET: if (w_sof_last) w_next = S_LAUNCH;
      S_LAUNCH:      if (w_key5_rise) w_next = S_PLAY;
      S_PLAY:
        if (score >= WIN_LIM) w_next = S_WIN;
        else if (collisionBallBottom) w_next = (life <= 4'd1) ? S_GAME_OVER : S_LEVEL_RESET;
`ifdef SCREEN_PAUSE_EN
        else if (w_pause_rise) w_next = S_PAUSED;
      S_PAUSED:      if (w_pause_rise) w_next = S_PLAY;
`endif
      S_GAME_OVER,
      S_WIN:         if (w_sof_last) w_next = S_INTRO;
      default:       w_next = S_INTRO;
    endcase
  end
  // state, frame counter, key history and outputs decoded from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= S_INTRO;
      r_cnt             <= 8'd0;
      r_key5_d          <= 1'b0;
`ifdef SCREEN_PAUSE_EN
      r_pause_d         <= 1'b0;
`endif
      screenSel         <= 2'd0;
      reset_level       <= 1'b1;
      reset_level_pulse <= 1'b0;
      pause             <= 1'b1;
      gameActive        <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_key5_d          <= key5IsPressed;
`ifdef SCREEN_PAUSE_EN
      r_pause_d         <= pauseKey;
`endif
      r_cnt             <= (w_entry && w_next == S_LEVEL_RESET) ? RESET_LOAD :
                           (w_entry && (w_next == S_GAME_OVER || w_next == S_WIN)) ? END_LOAD :
                           (startOfFrame && r_cnt != 8'd0) ? r_cnt - 8'd1 : r_cnt;
      screenSel         <= (w_next == S_INTRO) ? 2'd0 : (w_next == S_GAME_OVER) ? 2'd2 :
                           (w_next == S_WIN) ? 2'd3 : 2'd1;
      reset_level       <= w_next inside {S_INTRO, S_LEVEL_RESET, S_GAME_OVER, S_WIN};
      reset_level_pulse <= w_entry && w_next == S_LEVEL_RESET;
      pause             <= w_next != S_PLAY;
      gameActive        <= !(w_next inside {S_INTRO, S_GAME_OVER, S_WIN});
    end
  end
endmodule

// File: tb/tb_screen_sequencer.sv
// tb_screen_sequencer: directed scenarios plus random traffic checked against a frame-level game-flow model
module tb_screen_sequencer;
  localparam int RF = 3;
  localparam int EF = 4;
  localparam int WS = 9;
`ifdef SCREEN_PAUSE_EN
  localparam bit PAUSE_EN = 1'b1;
`else
  localparam bit PAUSE_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset, startOfFrame, start, key5IsPressed, collisionBallBottom, pauseKey;
  logic [3:0] life, score;
  logic [1:0] screenSel;
  logic reset_level, reset_level_pulse, pause, gameActive;
  logic [5:0] w_dut;
  assign w_dut = {screenSel, reset_level, reset_level_pulse, pause, gameActive};
  always #5 clk = ~clk;
  screen_sequencer #(.RESET_FRAMES(RF), .END_FRAMES(EF), .WIN_SCORE(WS)) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .start(start),
    .key5IsPressed(key5IsPressed), .collisionBallBottom(collisionBallBottom),
    .life(life), .score(score), .pauseKey(pauseKey), .screenSel(screenSel),
    .reset_level(reset_level), .reset_level_pulse(reset_level_pulse),
    .pause(pause), .gameActive(gameActive)
  );
  typedef struct packed {
    logic rst, sof, st, k5, coll;
    logic [3:0] life, score;
    logic pk;
  } stim_t;
  typedef enum {M_INTRO, M_LOAD, M_LAUNCH, M_PLAY, M_PAUSED, M_OVER, M_WIN} mode_t;
  stim_t q[$];
  int n_cmp = 0;
  int n_err = 0;
  mode_t m_mode = M_INTRO;
  int m_frames = 0;
  bit m_k5p = 0, m_pkp = 0, m_pulse = 0, m_just = 0;
  function automatic stim_t s(logic rst, logic sof, logic st, logic k5, logic coll,
                              logic [3:0] lf, logic [3:0] sc, logic pk);
    stim_t x;
    x.rst = rst; x.sof = sof; x.st = st; x.k5 = k5; x.coll = coll;
    x.life = lf; x.score = sc; x.pk = pk;
    return x;
  endfunction
  function automatic logic [5:0] exp_vec();
    logic [1:0] sel;
    sel = (m_mode == M_INTRO) ? 2'd0 : (m_mode == M_OVER) ? 2'd2 : (m_mode == M_WIN) ? 2'd3 : 2'd1;
    return {sel, m_mode inside {M_INTRO, M_LOAD, M_OVER, M_WIN}, m_pulse,
            m_mode != M_PLAY, m_mode inside {M_LOAD, M_LAUNCH, M_PLAY, M_PAUSED}};
  endfunction
  task automatic model_step(input stim_t x);
    mode_t old;
    bit k5r, pkr;
    old = m_mode;
    k5r = x.k5 && !m_k5p;
    pkr = x.pk && !m_pkp;
    if (x.rst) begin
      m_mode = M_INTRO; m_frames = 0; m_k5p = 0; m_pkp = 0; m_pulse = 0; m_just = 0;
      return;
    end
    m_k5p = x.k5;
    m_pkp = x.pk;
    case (m_mode)
      M_INTRO:  if (x.st) m_mode = M_LOAD;
      M_LOAD, M_OVER, M_WIN:
        if (x.sof) begin
          m_frames--;
          if (m_frames == 0) m_mode = (m_mode == M_LOAD) ? M_LAUNCH : M_INTRO;
        end
      M_LAUNCH: if (k5r) m_mode = M_PLAY;
      M_PLAY:
        if (x.score >= WS) m_mode = M_WIN;
        else if (x.coll) m_mode = (x.life <= 1) ? M_OVER : M_LOAD;
        else if (PAUSE_EN && pkr) m_mode = M_PAUSED;
      M_PAUSED: if (pkr) m_mode = M_PLAY;
      default: ;
    endcase
    m_just = m_mode != old;
    if (m_just) m_frames = (m_mode == M_LOAD) ? RF : (m_mode inside {M_OVER, M_WIN}) ? EF : 0;
    m_pulse = m_just && m_mode == M_LOAD;
  endtask
  task automatic tick(input stim_t x);
    reset = x.rst; startOfFrame = x.sof; start = x.st; key5IsPressed = x.k5;
    collisionBallBottom = x.coll; life = x.life; score = x.score; pauseKey = x.pk;
    model_step(x);
    @(posedge clk);
    #1;
  endtask
  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 0));
  endtask
  task automatic push_frames(input int n);
    for (int i = 0; i < n; i++) begin
      q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 0));
      q.push_back(s(0, 1, 0, 0, 0, 4'd3, 4'd0, 0));
    end
  endtask
  task automatic push_to_play();
    q.push_back(s(0, 0, 1, 0, 0, 4'd3, 4'd0, 0));
    push_frames(RF);
    q.push_back(s(0, 0, 0, 1, 0, 4'd3, 4'd0, 0));
    q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 0));
  endtask
  task automatic test_reset();
    q.push_back(s(1, 0, 0, 0, 0, 4'd3, 4'd0, 0));
    q.push_back(s(1, 0, 0, 0, 0, 4'd3, 4'd0, 0));
    push_idle(3);
    while (q.size() > 0) begin
      tick(q.pop_front());
      n_cmp++;
      if (w_dut !== exp_vec() || w_dut !== 6'b00_1_0_1_0) begin
        n_err++;
        $display("FAIL reset: dut=%b expected=%b", w_dut, 6'b00_1_0_1_0);
      end
    end
  endtask
  task automatic test_level_reset();
    q.push_back(s(0, 0, 1, 1, 0, 4'd3, 4'd0, 0));
    for (int i = 0; i < RF; i++) begin
      q.push_back(s(0, 0, 1, 1, 0, 4'd3, 4'd0, 0));
      q.push_back(s(0, 1, 0, 1, 0, 4'd3, 4'd0, 0));
    end
    q.push_back(s(0, 0, 0, 1, 0, 4'd3, 4'd0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(q.pop_front());
      n_cmp++;
      if (w_dut !== exp_vec() || (i == 0 && w_dut !== 6'b01_1_1_1_1) ||
          (q.size() == 0 && w_dut !== 6'b01_0_0_1_1)) begin
        n_err++;
        $display("FAIL level_reset[%0d]: dut=%b model=%b", i, w_dut, exp_vec());
      end
    end
  endtask
  task automatic test_launch();
    for (int i = 0; i < 4; i++) q.push_back(s(0, 0, 0, 1, 0, 4'd3, 4'd0, 0));
    push_idle(2);
    q.push_back(s(0, 0, 0, 1, 0, 4'd3, 4'd0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(q.pop_front());
      n_cmp++;
      if (w_dut !== exp_vec() || (q.size() == 0 && w_dut !== 6'b01_0_0_0_1) ||
          (i < 6 && w_dut !== 6'b01_0_0_1_1)) begin
        n_err++;
        $display("FAIL launch[%0d]: dut=%b model=%b", i, w_dut, exp_vec());
      end
    end
  endtask
  task automatic test_lives();
    q.push_back(s(0, 0, 0, 0, 1, 4'd2, 4'd0, 0));
    push_frames(RF);
    q.push_back(s(0, 0, 0, 1, 0, 4'd3, 4'd0, 0));
    q.push_back(s(0, 0, 0, 0, 1, 4'd1, 4'd0, 0));
    for (int i = 0; i < EF; i++) begin
      q.push_back(s(0, 0, 1, 0, 0, 4'd3, 4'd0, 0));
      q.push_back(s(0, 1, 0, 0, 0, 4'd3, 4'd0, 0));
    end
    for (int i = 0; q.size() > 0; i++) begin
      tick(q.pop_front());
      n_cmp++;
      if (w_dut !== exp_vec() || (i == 0 && w_dut !== 6'b01_1_1_1_1) ||
          (i == 2 * RF + 2 && w_dut !== 6'b10_1_0_1_0) ||
          (q.size() == 0 && w_dut !== 6'b00_1_0_1_0)) begin
        n_err++;
        $display("FAIL lives[%0d]: dut=%b model=%b", i, w_dut, exp_vec());
      end
    end
  endtask
  task automatic test_win();
    push_to_play();
    q.push_back(s(0, 0, 0, 0, 1, 4'd1, 4'd9, 0));
    push_frames(EF);
    for (int i = 0; q.size() > 0; i++) begin
      tick(q.pop_front());
      n_cmp++;
      if (w_dut !== exp_vec() || (i == 2 * RF + 3 && w_dut !== 6'b11_1_0_1_0)) begin
        n_err++;
        $display("FAIL win[%0d]: dut=%b model=%b", i, w_dut, exp_vec());
      end
    end
  endtask
  task automatic test_pause();
    push_to_play();
    q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 1));
    q.push_back(s(0, 0, 0, 0, 1, 4'd1, 4'd0, 1));
    q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 0));
    q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 1));
    q.push_back(s(0, 0, 0, 0, 0, 4'd3, 4'd0, 0));
    q.push_back(s(0, 0, 0, 0, 1, 4'd1, 4'd0, 0));
    q.push_back(s(1, 0, 0, 0, 0, 4'd3, 4'd0, 0));
    for (int i = 0; q.size() > 0; i++) begin
      tick(q.pop_front());
      n_cmp++;
      if (w_dut !== exp_vec() || (i == 2 * RF + 3 && pause !== PAUSE_EN)) begin
        n_err++;
        $display("FAIL pause[%0d]: dut=%b model=%b", i, w_dut, exp_vec());
      end
    end
  endtask
  task automatic test_random();
    stim_t x;
    for (int i = 0; i < 3000; i++) begin
      x = s($urandom_range(299) == 0, !m_just && $urandom_range(3) == 0,
            $urandom_range(7) == 0, $urandom_range(2) == 0, $urandom_range(11) == 0,
            4'($urandom_range(3)),
            ($urandom_range(5) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(8)),
            $urandom_range(2) == 0);
      tick(x);
      n_cmp++;
      if (w_dut !== exp_vec()) begin
        n_err++;
        $display("FAIL random[%0d]: dut=%b model=%b", i, w_dut, exp_vec());
      end
    end
  endtask
  initial begin
    reset = 1'b1; startOfFrame = 1'b0; start = 1'b0; key5IsPressed = 1'b0;
    collisionBallBottom = 1'b0; life = 4'd3; score = 4'd0; pauseKey = 1'b0;
    test_reset();
    test_level_reset();
    test_launch();
    test_lives();
    test_win();
    test_pause();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
